// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SIZE_* : req_size encodings (11 is reserved and always faults)
//   state_t: FSM encoding
//   is_aligned(): alignment/legality check on size and the low address bits
package lsu_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  is_aligned = 1'b1;
      SIZE_H:  is_aligned = ~off[0];
      SIZE_W:  is_aligned = (off == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and dataMemory-side bus of the load/store unit.
//   slave : LSU view (takes requests, drives memory)
//   master: environment view (pipeline + dataMemory)
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic for little-endian sub-word accesses.
//   word      : memory word read this cycle
//   wdata     : right-justified store data
//   off/size  : byte offset in the word and access size
//   sgn       : sign-extend sub-word loads
//   load_data : extracted/extended load value (0 for reserved size)
//   merge_data: word with the target byte/half replaced by wdata
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [4:0]  bsh, hsh;
  logic [31:0] bsel, hsel;

  assign bsh  = {off, 3'b000};
  assign hsh  = {off[1], 4'b0000};
  assign bsel = word >> bsh;
  assign hsel = word >> hsh;

  always_comb begin
    load_data  = '0;
    merge_data = word;
    case (size)
      SIZE_B: begin
        load_data  = {{24{sgn & bsel[7]}}, bsel[7:0]};
        merge_data = (word & ~(32'h0000_00FF << bsh)) | ((wdata & 32'h0000_00FF) << bsh);
      end
      SIZE_H: begin
        load_data  = {{16{sgn & hsel[15]}}, hsel[15:0]};
        merge_data = (word & ~(32'h0000_FFFF << hsh)) | ((wdata & 32'h0000_FFFF) << hsh);
      end
      SIZE_W: begin
        load_data  = word;
        merge_data = wdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-addressed 32-bit dataMemory.
// Byte-addressed byte/half/word loads and stores; sub-word stores take a
// two-cycle read-modify-write during which req_ready is low.
//   clk, rst : clock, async active-high reset
//   bus      : request/response + memory bus (slave modport)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst,
  load_store_unit_if.slave bus
);
  state_t state, state_nxt;

  logic [ADDR_W-1:0] rmw_addr;
  logic [31:0]       rmw_data;
  logic [31:0]       load_data, merge_data;
  logic              req_err, accept, sub_store, word_store;

  assign req_err    = ~is_aligned(bus.req_size, bus.req_addr[1:0]);
  assign accept     = (state == IDLE) & bus.req_valid;
  assign word_store = accept & bus.req_we & ~req_err & (bus.req_size == SIZE_W);
  assign sub_store  = accept & bus.req_we & ~req_err & (bus.req_size != SIZE_W);

  lsu_lane_merge u_lane (
    .word       (bus.mem_rdata),
    .wdata      (bus.req_wdata),
    .off        (bus.req_addr[1:0]),
    .size       (bus.req_size),
    .sgn        (bus.req_signed),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sub_store) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gating mem_we with rst keeps the write strobe off the instant reset
  // rises, even while a word store is being presented in IDLE.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.mem_we    = ~rst & ((state == RMW_WR) | word_store);
    bus.mem_addr  = {{(32-ADDR_W){1'b0}}, bus.req_addr[ADDR_W+1:2]};
    bus.mem_wdata = bus.req_wdata;
    if (state == RMW_WR) begin
      bus.mem_addr  = {{(32-ADDR_W){1'b0}}, rmw_addr};
      bus.mem_wdata = rmw_data;
    end
  end

  // Responses are registered: every accepted load/error/word store answers
  // the next cycle; a sub-word store answers when RMW_WR completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      rmw_addr       <= '0;
      rmw_data       <= '0;
    end else begin
      bus.resp_valid <= (accept & ~sub_store) | (state == RMW_WR);
      bus.resp_err   <= accept & req_err;
      bus.resp_rdata <= (accept & ~bus.req_we & ~req_err) ? load_data : 32'h0;
      if (sub_store) begin
        rmw_addr <= bus.req_addr[ADDR_W+1:2];
        rmw_data <= merge_data;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural dataMemory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  logic [31:0] mem [0:1023];

  load_store_unit_if bus();

  load_store_unit #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // dataMemory: combinational read, synchronous write
  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h8C0A0020;
      mem[32] <= 32'h55555555;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
  end
  always @(posedge clk) if (bus.mem_we) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response. The first
  // post-accept snapshot is returned so RMW_WR behaviour can be checked.
  task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err,
                     output logic rdy0, output logic we0,
                     output logic [31:0] addr0, output logic [31:0] wd0);
    logic got;
    got = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rdy0 = bus.req_ready; we0 = bus.mem_we; addr0 = bus.mem_addr; wd0 = bus.mem_wdata;
    for (int n = 0; n < 4 && !got; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1; rdata = bus.resp_rdata; err = bus.resp_err;
      end
    end
    if (!got) begin
      rdata = 32'hxxxxxxxx; err = 1'bx;
      chk("resp_timeout", 32'h0, 32'h1);
    end
  endtask

  logic [31:0] rd, a0, w0;
  logic        er, r0, e0;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SIZE_W;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    mem_init = 1'b1;
    @(posedge clk); #1 mem_init = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    rst = 1'b0;
    #1 chk("rst_ready", {31'b0, bus.req_ready}, 32'h1);

    // 1. back-to-back loads
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SIZE_W; bus.req_addr = 32'h80;
    @(posedge clk); #1 bus.req_addr = 32'h00;
    @(negedge clk);
    chk("t1_v0", {31'b0, bus.resp_valid}, 32'h1);
    chk("t1_d0", bus.resp_rdata, 32'h55555555);
    chk("t1_e0", {31'b0, bus.resp_err}, 32'h0);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t1_v1", {31'b0, bus.resp_valid}, 32'h1);
    chk("t1_d1", bus.resp_rdata, 32'h8C0A0020);
    @(negedge clk);
    chk("t1_pulse", {31'b0, bus.resp_valid}, 32'h0);

    // 2. byte store via RMW
    req(1'b1, SIZE_B, 1'b0, 32'h81, 32'h000000AB, rd, er, r0, e0, a0, w0);
    chk("t2_ready", {31'b0, r0}, 32'h0);
    chk("t2_we", {31'b0, e0}, 32'h1);
    chk("t2_addr", a0, 32'd32);
    chk("t2_wdata", w0, 32'h5555AB55);
    chk("t2_resp", rd, 32'h0);
    req(1'b0, SIZE_W, 1'b0, 32'h80, 32'h0, rd, er, r0, e0, a0, w0);
    chk("t2_lw", rd, 32'h5555AB55);

    // 3. sub-word loads
    req(1'b0, SIZE_B, 1'b1, 32'h81, 32'h0, rd, er, r0, e0, a0, w0);
    chk("t3_lb", rd, 32'hFFFFFFAB);
    req(1'b0, SIZE_B, 1'b0, 32'h81, 32'h0, rd, er, r0, e0, a0, w0);
    chk("t3_lbu", rd, 32'h000000AB);
    req(1'b0, SIZE_H, 1'b1, 32'h82, 32'h0, rd, er, r0, e0, a0, w0);
    chk("t3_lh", rd, 32'h00005555);

    // 4. half store
    req(1'b1, SIZE_H, 1'b0, 32'h82, 32'h00001234, rd, er, r0, e0, a0, w0);
    chk("t4_mem", mem[32], 32'h1234AB55);
    req(1'b0, SIZE_H, 1'b1, 32'h82, 32'h0, rd, er, r0, e0, a0, w0);
    chk("t4_lh", rd, 32'h00001234);

    // 5. misaligned / reserved size
    we_cnt = 0;
    req(1'b0, SIZE_W, 1'b0, 32'h82, 32'h0, rd, er, r0, e0, a0, w0);
    chk("t5_lw_err", {31'b0, er}, 32'h1);
    chk("t5_lw_rd", rd, 32'h0);
    req(1'b1, SIZE_H, 1'b0, 32'h81, 32'hFFFF, rd, er, r0, e0, a0, w0);
    chk("t5_sh_err", {31'b0, er}, 32'h1);
    chk("t5_sh_rd", rd, 32'h0);
    req(1'b1, 2'b11, 1'b0, 32'h80, 32'hFFFFFFFF, rd, er, r0, e0, a0, w0);
    chk("t5_rsv_err", {31'b0, er}, 32'h1);
    chk("t5_we_cnt", we_cnt, 32'h0);
    chk("t5_mem", mem[32], 32'h1234AB55);

    // word store/load and address wrap (0x1080 -> word 32)
    req(1'b1, SIZE_W, 1'b0, 32'h84, 32'hDEADBEEF, rd, er, r0, e0, a0, w0);
    chk("sw_err", {31'b0, er}, 32'h0);
    chk("sw_mem", mem[33], 32'hDEADBEEF);
    req(1'b0, SIZE_W, 1'b0, 32'h1080, 32'h0, rd, er, r0, e0, a0, w0);
    chk("wrap_lw", rd, 32'h1234AB55);

    // 6. reset during RMW_WR
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SIZE_B;
    bus.req_addr = 32'h80; bus.req_wdata = 32'hCD;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    chk("t6_we_pre", {31'b0, bus.mem_we}, 32'h1);
    #1 rst = 1'b1;
    #1 chk("t6_we_rst", {31'b0, bus.mem_we}, 32'h0);
    chk("t6_vld_rst", {31'b0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    chk("t6_mem", mem[32], 32'h1234AB55);
    chk("t6_vld", {31'b0, bus.resp_valid}, 32'h0);
    rst = 1'b0;
    #1 chk("t6_ready", {31'b0, bus.req_ready}, 32'h1);
    @(negedge clk);
    chk("t6_vld_after", {31'b0, bus.resp_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
